// File: rtl/multi_ro_unpacker_pkg.sv
// Shared definitions for the readout unpacker: one-hot FSM states, trailer tag, header flag position.
package multi_ro_unpacker_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_HDR     = 4'b0010,
    ST_DATA    = 4'b0100,
    ST_TRAILER = 4'b1000
  } state_t;

  localparam logic [3:0] TRAILER_TAG = 4'hF;
  localparam int         DROP_CNT_W  = 8;

  // The header flag sits just above the payload in every FIFO word.
  function automatic int hdr_flag_bit(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/multi_ro_unpacker_if.sv
// Readout FIFO read port, framed output stream and status, bundled for the unpacker.
interface multi_ro_unpacker_if #(
  parameter int DW = 16
);
  import multi_ro_unpacker_pkg::*;

  logic                  FIFO_EMPTY;
  logic [DW:0]           FIFO_Q;
  logic                  RD_EN;
  logic [DW-1:0]         OUT_DATA;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic                  OUT_SOP;
  logic                  OUT_EOP;
  logic [DROP_CNT_W-1:0] DROP_CNT;
  logic                  BUSY;

  modport master (
    input  FIFO_EMPTY, FIFO_Q, OUT_READY,
    output RD_EN, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, DROP_CNT, BUSY
  );

  modport slave (
    output FIFO_EMPTY, FIFO_Q, OUT_READY,
    input  RD_EN, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, DROP_CNT, BUSY
  );

endinterface

// File: rtl/multi_ro_unpacker_ro_fifo_prefetch.sv
// Two-entry prefetch buffer in front of the readout FIFO (read data arrives the cycle after RD_EN).
// The slot freed by this cycle's pop is counted as available, so one pop per cycle is sustained.
module multi_ro_unpacker_ro_fifo_prefetch #(
  parameter int DW = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fifo_empty,
  input  logic [DW:0] fifo_q,
  output logic        rd_en,
  output logic        head_valid,
  output logic [DW:0] head_word,
  input  logic        pop
);

  logic [DW:0] entry0_q;
  logic [DW:0] entry1_q;
  logic [1:0]  occ_q;
  logic        in_flight_q;
  logic [1:0]  occ_left;
  logic        push;

  assign push       = in_flight_q;
  assign occ_left   = occ_q - {1'b0, pop};
  // No read is launched during reset; one returning during reset is never captured.
  assign rd_en      = !RST && !fifo_empty && ((occ_left + {1'b0, in_flight_q}) < 2'd2);
  assign head_valid = (occ_q != 2'd0);
  assign head_word  = entry0_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      entry0_q    <= '0;
      entry1_q    <= '0;
      occ_q       <= 2'd0;
      in_flight_q <= 1'b0;
    end else begin
      in_flight_q <= rd_en;
      case ({push, pop})
        2'b01: begin
          entry0_q <= entry1_q;
          occ_q    <= occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) entry0_q <= fifo_q;
          else               entry1_q <= fifo_q;
          occ_q <= occ_q + 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            entry0_q <= fifo_q;
          end else begin
            entry0_q <= entry1_q;
            entry1_q <= fifo_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_ro_unpacker.sv
// Frames readout-FIFO words as header(SOP) / samples / generated trailer(EOP) on a valid/ready stream.
// Header shows one cycle after it heads the prefetch; outputs come from registers only and hold while stalled.
module multi_ro_unpacker
  import multi_ro_unpacker_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input logic                 CLK,
  input logic                 RST,
  multi_ro_unpacker_if.master bus
);

  localparam int CNT_W    = DW - 4;
  localparam int STARVE_W = $clog2(TIMEOUT + 1);
  localparam int HDR_BIT  = hdr_flag_bit(DW);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(TIMEOUT - 1);

  logic                  rd_en;
  logic                  head_valid;
  logic [DW:0]           head_word;
  logic                  pop;
  logic                  head_is_hdr;
  logic [DW-1:0]         head_payload;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [STARVE_W-1:0]   starve_q;
  logic [STARVE_W-1:0]   starve_d;
  logic [DROP_CNT_W-1:0] drop_q;
  logic [DROP_CNT_W-1:0] drop_d;

  logic                  out_valid;
  logic                  out_sop;
  logic                  out_eop;
  logic [DW-1:0]         out_data;

  multi_ro_unpacker_ro_fifo_prefetch #(
    .DW(DW)
  ) u_ro_fifo_prefetch (
    .CLK        (CLK),
    .RST        (RST),
    .fifo_empty (bus.FIFO_EMPTY),
    .fifo_q     (bus.FIFO_Q),
    .rd_en      (rd_en),
    .head_valid (head_valid),
    .head_word  (head_word),
    .pop        (pop)
  );

  assign head_is_hdr  = head_word[HDR_BIT];
  assign head_payload = head_word[DW-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    drop_d    = drop_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (head_valid) begin
          if (head_is_hdr) begin
            state_d = ST_HDR;
          end else begin
            // Orphan sample with no open packet: discard it.
            pop = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 8'd1;
          end
        end
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_sop   = 1'b1;
        out_data  = head_payload;
        if (bus.OUT_READY) begin
          pop      = 1'b1;
          cnt_d    = '0;
          starve_d = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (head_valid) begin
          starve_d = '0;
          if (head_is_hdr) begin
            state_d = ST_TRAILER;
          end else begin
            out_valid = 1'b1;
            out_data  = head_payload;
            if (bus.OUT_READY) begin
              pop = 1'b1;
              if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else if (starve_q == STARVE_LAST) begin
          starve_d = '0;
          state_d  = ST_TRAILER;
        end else begin
          starve_d = starve_q + STARVE_W'(1);
        end
      end
      ST_TRAILER: begin
        out_valid = 1'b1;
        out_eop   = 1'b1;
        out_data  = {TRAILER_TAG, cnt_q};
        if (bus.OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.RD_EN     = rd_en;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_SOP   = out_sop;
  assign bus.OUT_EOP   = out_eop;
  assign bus.OUT_DATA  = out_data;
  assign bus.DROP_CNT  = drop_q;
  assign bus.BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multi_ro_unpacker.sv
// Directed bench for multi_ro_unpacker: FIFO model feeds words, a negedge monitor scores the stream.
module tb_multi_ro_unpacker;

  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic CLK = 1'b0;
  logic RST;

  multi_ro_unpacker_if #(.DW(DW)) bus ();

  multi_ro_unpacker #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_xfer_cyc = 0;
  int          ready_mode = 0;   // 0: low, 1: high, 2: random
  logic        rd_s = 1'b0;
  logic [DW:0]   fq[$];          // readout FIFO contents {flag, payload}
  logic [DW+1:0] exp_q[$];       // expected stream words {sop, eop, data}
  int            eop_gaps[$];    // cycles from previous transfer to each trailer

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fpush(input logic flag, input logic [DW-1:0] d);
    fq.push_back({flag, d});
  endtask

  task automatic expect_word(input logic sop, input logic eop, input logic [DW-1:0] d);
    exp_q.push_back({sop, eop, d});
  endtask

  function automatic int gap_at(input int idx);
    if (idx < eop_gaps.size()) return eop_gaps[idx];
    return -1;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(exp_q.size() == 0 && fq.size() == 0 && !bus.BUSY) && n < budget);
    check(name, (n < budget), 1);
    repeat (4) @(negedge CLK);
  endtask

  // FIFO model: a read seen at the negedge pops at the next posedge; data is valid the following cycle.
  initial begin
    bus.FIFO_EMPTY = 1'b1;
    bus.FIFO_Q     = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (rd_s) begin
        if (fq.size() > 0) bus.FIFO_Q = fq.pop_front();
        else check("fifo_underflow", 1, 0);
      end
      bus.FIFO_EMPTY = (fq.size() == 0);
    end
  end

  initial begin
    bus.OUT_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        1:       bus.OUT_READY = 1'b1;
        2:       bus.OUT_READY = ($urandom_range(0, 1) == 1);
        default: bus.OUT_READY = 1'b0;
      endcase
    end
  end

  // Monitor: scores transfers, checks hold-while-stalled and SOP/EOP exclusivity.
  initial begin
    logic          stalled;
    logic [DW+1:0] held;
    logic [DW+1:0] e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      rd_s = bus.RD_EN;
      if (RST) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          check("hold_while_stalled", {bus.OUT_VALID, bus.OUT_SOP, bus.OUT_EOP, bus.OUT_DATA}, {1'b1, held});
        if (bus.OUT_VALID)
          check("sop_eop_exclusive", {31'd0, bus.OUT_SOP & bus.OUT_EOP}, 0);
        stalled = bus.OUT_VALID && !bus.OUT_READY;
        held    = {bus.OUT_SOP, bus.OUT_EOP, bus.OUT_DATA};
        if (bus.OUT_VALID && bus.OUT_READY) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {bus.OUT_SOP, bus.OUT_EOP, bus.OUT_DATA}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("stream_word", {bus.OUT_SOP, bus.OUT_EOP, bus.OUT_DATA}, e);
          end
          if (bus.OUT_EOP) eop_gaps.push_back(cyc - last_xfer_cyc);
          last_xfer_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_rd_en",     bus.RD_EN,     0);
    check("rst_out_valid", bus.OUT_VALID, 0);
    check("rst_out_sop",   bus.OUT_SOP,   0);
    check("rst_out_eop",   bus.OUT_EOP,   0);
    check("rst_out_data",  bus.OUT_DATA,  0);
    check("rst_drop_cnt",  bus.DROP_CNT,  0);
    check("rst_busy",      bus.BUSY,      0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ready_mode = 1;

    // 1: single packet closed by starvation timeout
    eop_gaps.delete();
    fpush(1, 16'h00A5); fpush(0, 16'h0001); fpush(0, 16'h0002); fpush(0, 16'h0003);
    expect_word(1, 0, 16'h00A5); expect_word(0, 0, 16'h0001);
    expect_word(0, 0, 16'h0002); expect_word(0, 0, 16'h0003);
    expect_word(0, 1, 16'hF003);
    wait_idle("t1_done", 200);
    check("t1_timeout_gap", gap_at(0), TIMEOUT + 1);

    // 2: back-to-back packets, first closed by the next header
    eop_gaps.delete();
    fpush(1, 16'h0B01); fpush(0, 16'h0011); fpush(0, 16'h0012);
    fpush(1, 16'h0B02); fpush(0, 16'h0021);
    expect_word(1, 0, 16'h0B01); expect_word(0, 0, 16'h0011); expect_word(0, 0, 16'h0012);
    expect_word(0, 1, 16'hF002);
    expect_word(1, 0, 16'h0B02); expect_word(0, 0, 16'h0021);
    expect_word(0, 1, 16'hF001);
    wait_idle("t2_done", 200);
    check("t2_close_on_hdr", (gap_at(0) >= 1 && gap_at(0) < TIMEOUT), 1);
    check("t2_timeout_gap", gap_at(1), TIMEOUT + 1);

    // 3: 200 samples under random backpressure
    ready_mode = 2;
    fpush(1, 16'h0C03);
    expect_word(1, 0, 16'h0C03);
    for (int i = 0; i < 200; i++) begin
      fpush(0, 16'h3000 + 16'(i));
      expect_word(0, 0, 16'h3000 + 16'(i));
    end
    expect_word(0, 1, 16'hF0C8);
    wait_idle("t3_done", 3000);
    ready_mode = 1;

    // 4: orphans before a header, then saturation of the drop counter
    for (int i = 0; i < 3; i++) fpush(0, 16'h0DD0 + 16'(i));
    fpush(1, 16'h0D04); fpush(0, 16'h0041);
    expect_word(1, 0, 16'h0D04); expect_word(0, 0, 16'h0041);
    expect_word(0, 1, 16'hF001);
    wait_idle("t4_done", 200);
    check("t4_drop_cnt_3", bus.DROP_CNT, 3);
    for (int i = 0; i < 300; i++) fpush(0, 16'h5000 + 16'(i));
    wait_idle("t4_orphans_done", 1000);
    check("t4_drop_cnt_sat", bus.DROP_CNT, 255);
    check("t4_busy_after_orphans", bus.BUSY, 0);

    // 5: reset mid-DATA with a read in flight
    fpush(1, 16'h0E05);
    expect_word(1, 0, 16'h0E05);
    begin
      int n = 0;
      do begin @(negedge CLK); n++; end while (exp_q.size() != 0 && n < 50);
      check("t5_header_sent", (n < 50), 1);
    end
    @(posedge CLK);
    #1;
    fpush(0, 16'h0E55);
    begin
      int n = 0;
      do begin @(negedge CLK); n++; end while (!bus.RD_EN && n < 5);
      check("t5_read_issued", (n < 5), 1);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("t5_rst_rd_en",     bus.RD_EN,     0);
    check("t5_rst_out_valid", bus.OUT_VALID, 0);
    check("t5_rst_out_sop",   bus.OUT_SOP,   0);
    check("t5_rst_out_eop",   bus.OUT_EOP,   0);
    check("t5_rst_out_data",  bus.OUT_DATA,  0);
    check("t5_rst_drop_cnt",  bus.DROP_CNT,  0);
    check("t5_rst_busy",      bus.BUSY,      0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    check("t5_void_read_taken", fq.size(), 0);
    check("t5_busy_after",      bus.BUSY,     0);
    check("t5_drop_cnt_after",  bus.DROP_CNT, 0);

    // 6: header immediately followed by a header
    eop_gaps.delete();
    fpush(1, 16'h0A06); fpush(1, 16'h0A07); fpush(0, 16'h0071);
    expect_word(1, 0, 16'h0A06); expect_word(0, 1, 16'hF000);
    expect_word(1, 0, 16'h0A07); expect_word(0, 0, 16'h0071);
    expect_word(0, 1, 16'hF001);
    wait_idle("t6_done", 200);
    check("t6_drop_cnt", bus.DROP_CNT, 0);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
